// File: rtl/p_s_pkg.sv
// Shared constants and helpers for the p_s parallel-to-serial converter.
// N must be a power of two so that bank addresses are simply {lane, column}.
package p_s_pkg;

  localparam int W      = 34;
  localparam int N      = 4;
  localparam int COL_W  = $clog2(N);
  localparam int IDX_W  = $clog2(N*N);
  localparam int LANE_W = IDX_W - COL_W;
  localparam int BLK_W  = N*W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N-1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N*N-1);

  function automatic logic [W-1:0] lane(input logic [BLK_W-1:0] beat, input int j);
    return beat[W*j +: W];
  endfunction

endpackage

// File: rtl/p_s_bank.sv
// One N*N-word block buffer: written a column (N lanes) at a time,
// read one word at a time by row-major index.
module p_s_bank
  import p_s_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [COL_W-1:0] i_col,
  input  logic [BLK_W-1:0] i_beat,
  input  logic [IDX_W-1:0] i_idx,
  output logic [W-1:0]     o_word
);

  logic [W-1:0] r_mem [N*N];

  // lane j of column c is word R(c + N*j), i.e. address {j, c}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N*N; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int j = 0; j < N; j++) r_mem[{LANE_W'(j), i_col}] <= lane(i_beat, j);
    end
  end

  assign o_word = r_mem[i_idx];

endmodule

// File: rtl/p_s.sv
// Double-buffered parallel-to-serial converter: N column beats in, N*N words out.
// One bank fills while the other drains; full[] is the only hand-off between sides.
module p_s
  import p_s_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             p_s_flag_in,
  input  logic [BLK_W-1:0] data_in_1,
  output logic             in_ready,
  output logic [W-1:0]     data_out_1,
  output logic             p_s_flag_out,
  input  logic             out_ready,
  output logic             out_last
);

  logic             r_wb;
  logic             r_rb;
  logic [1:0]       r_full;
  logic [COL_W-1:0] r_col;
  logic [IDX_W-1:0] r_idx;

  logic             w_acc_in;
  logic             w_acc_out;
  logic             w_blk_in_done;
  logic             w_blk_out_done;
  logic [W-1:0]     w_word0;
  logic [W-1:0]     w_word1;

  assign in_ready       = !r_full[r_wb];
  assign p_s_flag_out   = r_full[r_rb];
  assign w_acc_in       = p_s_flag_in && in_ready;
  assign w_acc_out      = p_s_flag_out && out_ready;
  assign w_blk_in_done  = w_acc_in && (r_col == COL_LAST);
  assign w_blk_out_done = w_acc_out && (r_idx == IDX_LAST);
  assign data_out_1     = r_rb ? w_word1 : w_word0;
  assign out_last       = p_s_flag_out && (r_idx == IDX_LAST);

  p_s_bank u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_acc_in && !r_wb),
    .i_col  (r_col),
    .i_beat (data_in_1),
    .i_idx  (r_idx),
    .o_word (w_word0)
  );

  p_s_bank u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_acc_in && r_wb),
    .i_col  (r_col),
    .i_beat (data_in_1),
    .i_idx  (r_idx),
    .o_word (w_word1)
  );

  // Set and clear never hit the same bit: a write needs !full[wb], a block end needs full[rb].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_full <= 2'b00;
      r_col  <= '0;
      r_idx  <= '0;
    end else begin
      if (w_acc_in) begin
        r_col <= r_col + 1'b1;
        if (w_blk_in_done) begin
          r_full[r_wb] <= 1'b1;
          r_wb         <= !r_wb;
        end
      end
      if (w_acc_out) begin
        r_idx <= r_idx + 1'b1;
        if (w_blk_out_done) begin
          r_full[r_rb] <= 1'b0;
          r_rb         <= !r_rb;
        end
      end
    end
  end

endmodule
